// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - registered forwarding-aware ALU operand select stage with valid/ready handshake
// Optional 2-entry output buffer enabled by defining ALU_OPSTAGE_SKID_EN.
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  RD1,
  input  logic [XLEN-1:0]  RD2,
  input  logic [XLEN-1:0]  ImmExt,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  ALUResultM,
  input  logic [XLEN-1:0]  ResultW,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [1:0]       ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [TAG_W-1:0] TagIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  SrcA,
  output logic [XLEN-1:0]  SrcB,
  output logic [XLEN-1:0]  WD,
  output logic [TAG_W-1:0] TagOut
);

  localparam logic [XLEN-1:0] CONST_FOUR = XLEN'(4);

  logic [XLEN-1:0] fwd_a, fwd_b, sel_a, sel_b;

  // Reserved encodings (11) fall through to the forwarded register value.
  always_comb begin
    fwd_a = RD1;
    case (ForwardAE)
      2'b01:   fwd_a = ResultW;
      2'b10:   fwd_a = ALUResultM;
      default: fwd_a = RD1;
    endcase
    fwd_b = RD2;
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2;
    endcase
    sel_a = fwd_a;
    case (ALUSrcA)
      2'b01:   sel_a = PC;
      2'b10:   sel_a = '0;
      default: sel_a = fwd_a;
    endcase
    sel_b = fwd_b;
    case (ALUSrcB)
      2'b01:   sel_b = ImmExt;
      2'b10:   sel_b = CONST_FOUR;
      default: sel_b = fwd_b;
    endcase
  end

  logic accept, consume;
  logic load_out_in;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

`ifdef ALU_OPSTAGE_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic             load_out_skid, load_skid;
  logic [XLEN-1:0]  skid_a, skid_b, skid_wd;
  logic [TAG_W-1:0] skid_tag;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_FULL;
            load_out_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && consume) begin
            load_out_in = 1'b1;
          end else if (accept) begin
            state_d   = ST_SKID;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (consume) begin
            state_d       = ST_FULL;
            load_out_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready is registered so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_SKID);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_a   <= '0;
      skid_b   <= '0;
      skid_wd  <= '0;
      skid_tag <= '0;
    end else if (load_skid) begin
      skid_a   <= sel_a;
      skid_b   <= sel_b;
      skid_wd  <= fwd_b;
      skid_tag <= TagIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SrcA   <= '0;
      SrcB   <= '0;
      WD     <= '0;
      TagOut <= '0;
    end else if (load_out_in) begin
      SrcA   <= sel_a;
      SrcB   <= sel_b;
      WD     <= fwd_b;
      TagOut <= TagIn;
    end else if (load_out_skid) begin
      SrcA   <= skid_a;
      SrcB   <= skid_b;
      WD     <= skid_wd;
      TagOut <= skid_tag;
    end
  end

`else
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t state_q, state_d;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;

  always_comb begin
    state_d     = state_q;
    load_out_in = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d     = ST_FULL;
      load_out_in = 1'b1;
    end else if (consume) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SrcA   <= '0;
      SrcB   <= '0;
      WD     <= '0;
      TagOut <= '0;
    end else if (load_out_in) begin
      SrcA   <= sel_a;
      SrcB   <= sel_b;
      WD     <= fwd_b;
      TagOut <= TagIn;
    end
  end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] RD1, RD2, ImmExt, PC, ALUResultM, ResultW;
  logic [1:0]  ForwardAE, ForwardBE, ALUSrcA, ALUSrcB;
  logic [7:0]  TagIn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA, SrcB, WD;
  logic [7:0]  TagOut;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt), .PC(PC),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .TagIn(TagIn),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .WD(WD), .TagOut(TagOut)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] tag);
    in_valid = 1'b1;
    TagIn    = tag;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] fwd_exp [4];

  initial begin
    fwd_exp[0] = 32'd1; fwd_exp[1] = 32'd2; fwd_exp[2] = 32'd3; fwd_exp[3] = 32'd1;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    RD1 = 32'd1; RD2 = 32'd12345678; ImmExt = 32'd87654321; PC = 32'h100;
    ALUResultM = 32'd3; ResultW = 32'd2; TagIn = 8'h5A;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00;

    // reset with in_valid held high
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_srca", SrcA, 32'd0);
      check("rst_srcb", SrcB, 32'd0);
      check("rst_wd", WD, 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b1;
    step();

    // B operand select, WD independent of ALUSrcB
    ALUSrcB = 2'b00; issue(8'h01);
    check("b_reg_valid", 32'(out_valid), 32'd1);
    check("b_reg_srcb", SrcB, 32'd12345678);
    check("b_reg_wd", WD, 32'd12345678);
    check("b_reg_tag", 32'(TagOut), 32'h01);
    ALUSrcB = 2'b01; issue(8'h02);
    check("b_imm_srcb", SrcB, 32'd87654321);
    check("b_imm_wd", WD, 32'd12345678);
    ALUSrcB = 2'b00;

    // A forwarding encodings
    for (int f = 0; f < 4; f++) begin
      ForwardAE = 2'(f);
      issue(8'(8'h10 + f));
      check($sformatf("fwd_a_%0d", f), SrcA, fwd_exp[f]);
    end
    ForwardAE = 2'b00;
    ALUSrcA = 2'b01; issue(8'h20); check("a_pc", SrcA, 32'h100);
    ALUSrcA = 2'b10; issue(8'h21); check("a_zero", SrcA, 32'd0);
    ALUSrcA = 2'b11; issue(8'h22); check("a_rsv", SrcA, 32'd1);
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b10; issue(8'h23); check("b_four", SrcB, 32'd4);
    ALUSrcB = 2'b11; ForwardBE = 2'b10; issue(8'h24);
    check("b_rsv_fwdm", SrcB, 32'd3);
    check("wd_fwdm", WD, 32'd3);
    ForwardBE = 2'b01; ALUSrcB = 2'b01; issue(8'h25);
    check("wd_fwdw", WD, 32'd2);
    ForwardBE = 2'b00; ALUSrcB = 2'b00;
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // backpressure
    out_ready = 1'b0;
`ifdef ALU_OPSTAGE_SKID_EN
    in_valid = 1'b1; TagIn = 8'h0A; step();
    check("bp_a_tag", 32'(TagOut), 32'h0A);
    check("bp_a_ready", 32'(in_ready), 32'd1);
    TagIn = 8'h0B; step();
    check("bp_b_held", 32'(TagOut), 32'h0A);
    check("bp_skid_ready", 32'(in_ready), 32'd0);
    TagIn = 8'h0C; step();
    check("bp_c_held", 32'(TagOut), 32'h0A);
    check("bp_c_stall", 32'(in_ready), 32'd0);
    out_ready = 1'b1; step();
    check("bp_out_b", 32'(TagOut), 32'h0B);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    check("bp_out_c", 32'(TagOut), 32'h0C);
    check("bp_c_valid", 32'(out_valid), 32'd1);
    step();
    check("bp_done", 32'(out_valid), 32'd0);
`else
    in_valid = 1'b1; TagIn = 8'h0A; step();
    check("bp_a_tag", 32'(TagOut), 32'h0A);
    check("bp_ready_low", 32'(in_ready), 32'd0);
    TagIn = 8'h0B; step();
    check("bp_a_held", 32'(TagOut), 32'h0A);
    out_ready = 1'b1; #1;
    check("bp_ready_comb", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    check("bp_out_b", 32'(TagOut), 32'h0B);
    step();
    check("bp_done", 32'(out_valid), 32'd0);
`endif

    // flush with held ops and an input offered on the flush cycle
    out_ready = 1'b0;
    issue(8'h40);
    issue(8'h41);
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_valid = 1'b1; TagIn = 8'h77;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    step();
    check("fl_dropped", 32'(out_valid), 32'd0);
    // flush dominates accept from the empty state
    flush = 1'b1; in_valid = 1'b1; TagIn = 8'h66;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_acc_drop", 32'(out_valid), 32'd0);

    // full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; TagIn = 8'(i);
      step();
      check($sformatf("tp_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("tp_tag_%0d", i), 32'(TagOut), 32'(i));
      check($sformatf("tp_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("tp_end", 32'(out_valid), 32'd0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    issue(8'h90);
    check("ar_pre", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0; #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_tag", 32'(TagOut), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
